demux_1x4_ot: RTL and testbench



---
 rtl/demux_1x4_ot.sv | 39 +++
 tb/tb_demux_1x4_ot.sv | 86 ++++++++
 2 files changed

// File: rtl/demux_1x4_ot.sv
// demux_1x4_ot: registered 1-to-4 demultiplexer with one-hot channel-selected flags
module demux_1x4_ot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             S1,
  input  logic             S0,
  input  logic             en,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3
);
  logic [1:0] sel;
  logic [3:0][WIDTH-1:0] y_d, y_q;
  logic [3:0] v_d, v_q;
  assign sel = {S1, S0};
  always_comb begin
    v_d = en ? 4'b0001 << sel : 4'b0000;
    for (int k = 0; k < 4; k++) y_d[k] = v_d[k] ? D : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
      v_q <= '0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end
  assign {Y3, Y2, Y1, Y0} = y_q;
  assign {V3, V2, V1, V0} = v_q;
endmodule

// File: tb/tb_demux_1x4_ot.sv
// tb_demux_1x4_ot: scoreboard bench; stimulus pushes model expectations, monitor checks after each edge
module tb_demux_1x4_ot;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n, s1, s0, en;
  logic [W-1:0] d, y0, y1, y2, y3;
  logic v0, v1, v2, v3;
  typedef struct {
    logic [W-1:0] y [4];
    logic [3:0]   v;
    string        tag;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  demux_1x4_ot #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .D(d), .S1(s1), .S0(s0), .en(en),
    .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
    .V0(v0), .V1(v1), .V2(v2), .V3(v3)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic e, input int sel, input logic [W-1:0] data, input string tag);
    exp_t x;
    rst_n = r;
    en = e;
    {s1, s0} = 2'(sel);
    d = data;
    for (int k = 0; k < 4; k++) begin
      x.y[k] = (r && e && k == sel) ? data : '0;
      x.v[k] = r && e && k == sel;
    end
    x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t x;
        logic [W-1:0] act [4];
        x = sb.pop_front();
        act = '{y0, y1, y2, y3};
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (act[k] !== x.y[k]) begin
            errors++;
            $display("FAIL %s Y%0d: got %h expected %h", x.tag, k, act[k], x.y[k]);
          end
        end
        checks++;
        if ({v3, v2, v1, v0} !== x.v) begin
          errors++;
          $display("FAIL %s V: got %b expected %b", x.tag, {v3, v2, v1, v0}, x.v);
        end
      end
    end
  end
  initial begin
    step(0, 1, 3, 8'h01, "reset0");
    step(0, 1, 3, 8'h01, "reset1");
    step(1, 1, 3, 8'h01, "release");
    for (int s = 0; s < 4; s++) step(1, 1, s, 8'h01, "d1_sweep");
    for (int s = 0; s < 4; s++) step(1, 1, s, 8'h00, "d0_sweep");
    step(1, 0, 2, 8'h01, "en_off");
    step(1, 1, 2, 8'h01, "en_on");
    step(1, 1, 1, 8'hA5, "wide_a5");
    step(1, 1, 3, 8'h3C, "wide_3c");
    step(1, 1, 2, 8'h01, "mid_route");
    step(0, 1, 2, 8'h01, "mid_reset");
    step(1, 1, 2, 8'h01, "mid_resume");
    step(1, 1, 2, 8'hFF, "mid_next");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3), W'($urandom), "random");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
